// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared encodings, FSM states and helpers for mem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // funct3 access-width encodings
    localparam logic [2:0] W_B  = 3'b000;
    localparam logic [2:0] W_H  = 3'b001;
    localparam logic [2:0] W_W  = 3'b010;
    localparam logic [2:0] W_BU = 3'b100;
    localparam logic [2:0] W_HU = 3'b101;

    localparam bit DEF_FIXED_PRIO = 1'b0;
    localparam int MEM_RD_LAT     = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_FIN  = 2'd3
    } arb_state_e;

    function automatic logic width_legal(input logic [2:0] width);
        return (width == W_B) || (width == W_H) || (width == W_W) ||
               (width == W_BU) || (width == W_HU);
    endfunction

    // Accesses wider than a byte drive both lanes in the LO beat.
    function automatic logic width_two_lanes(input logic [2:0] width);
        return (width == W_H) || (width == W_HU) || (width == W_W);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_extend
// Description : Assembles four load bytes into a sign/zero-extended result.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_extend
    import mem_arb_pkg::*;
(
    input  logic [2:0]  i_width,
    input  logic [7:0]  i_byte0,
    input  logic [7:0]  i_byte1,
    input  logic [7:0]  i_byte2,
    input  logic [7:0]  i_byte3,
    output logic [31:0] o_result
);

    always_comb begin
        o_result = 32'h0;
        case (i_width)
            W_B:     o_result = {{24{i_byte0[7]}}, i_byte0};
            W_BU:    o_result = {24'h0, i_byte0};
            W_H:     o_result = {{16{i_byte1[7]}}, i_byte1, i_byte0};
            W_HU:    o_result = {16'h0, i_byte1, i_byte0};
            W_W:     o_result = {i_byte3, i_byte2, i_byte1, i_byte0};
            default: o_result = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Two-requester arbiter onto a byte-wide dual-lane memory,
//               sequencing each access as one or two lane-pair beats.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter bit FIXED_PRIO = DEF_FIXED_PRIO
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [2:0]  m0_width,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [2:0]  m1_width,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,

    output logic        mem_en,
    output logic        mem_we_a,
    output logic        mem_we_b,
    output logic [31:0] mem_addr_a,
    output logic [31:0] mem_addr_b,
    output logic [7:0]  mem_wdata_a,
    output logic [7:0]  mem_wdata_b,
    input  logic [7:0]  mem_rdata_a,
    input  logic [7:0]  mem_rdata_b
);

    arb_state_e  r_state;
    arb_state_e  w_state_nxt;

    logic        r_rr_last;
    logic        r_owner;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_width;
    logic [15:0] r_lo16;

    logic        w_any_req;
    logic        w_pick_m1;
    logic        w_start;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [2:0]  w_sel_width;

    logic        w_en_nxt;
    logic        w_we_a_nxt;
    logic        w_we_b_nxt;
    logic [31:0] w_addr_a_nxt;
    logic [31:0] w_addr_b_nxt;
    logic [7:0]  w_wdata_a_nxt;
    logic [7:0]  w_wdata_b_nxt;
    logic        w_gnt0_nxt;
    logic        w_gnt1_nxt;
    logic        w_rv0_nxt;
    logic        w_rv1_nxt;

    logic        w_is_word;
    logic [7:0]  w_byte0;
    logic [7:0]  w_byte1;
    logic [31:0] w_ext;
    logic [31:0] w_resp;

    // ------------------------------------------------------------------
    // Arbitration: the requester that did not win last time gets priority
    // ------------------------------------------------------------------
    assign w_any_req = m0_req | m1_req;
    assign w_start   = (r_state == ST_IDLE) && w_any_req;

    always_comb begin
        w_pick_m1 = m1_req;
        if (m0_req && m1_req) begin
            w_pick_m1 = FIXED_PRIO ? 1'b0 : ~r_rr_last;
        end
    end

    assign w_sel_we    = w_pick_m1 ? m1_we    : m0_we;
    assign w_sel_addr  = w_pick_m1 ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_pick_m1 ? m1_wdata : m0_wdata;
    assign w_sel_width = w_pick_m1 ? m1_width : m0_width;

    // ------------------------------------------------------------------
    // Load assembly: a word's low half was captured during HI
    // ------------------------------------------------------------------
    assign w_is_word = (r_width == W_W);
    assign w_byte0   = w_is_word ? r_lo16[7:0]  : mem_rdata_a;
    assign w_byte1   = w_is_word ? r_lo16[15:8] : mem_rdata_b;

    mem_load_extend u_load_extend (
        .i_width  (r_width),
        .i_byte0  (w_byte0),
        .i_byte1  (w_byte1),
        .i_byte2  (mem_rdata_a),
        .i_byte3  (mem_rdata_b),
        .o_result (w_ext)
    );

    assign w_resp = r_we ? 32'h0 : w_ext;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and next registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_en_nxt      = 1'b0;
        w_we_a_nxt    = 1'b0;
        w_we_b_nxt    = 1'b0;
        w_addr_a_nxt  = mem_addr_a;
        w_addr_b_nxt  = mem_addr_b;
        w_wdata_a_nxt = mem_wdata_a;
        w_wdata_b_nxt = mem_wdata_b;
        w_gnt0_nxt    = 1'b0;
        w_gnt1_nxt    = 1'b0;
        w_rv0_nxt     = 1'b0;
        w_rv1_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_gnt0_nxt = ~w_pick_m1;
                    w_gnt1_nxt = w_pick_m1;
                    if (width_legal(w_sel_width)) begin
                        w_state_nxt   = ST_LO;
                        w_en_nxt      = 1'b1;
                        w_we_a_nxt    = w_sel_we;
                        w_we_b_nxt    = w_sel_we & width_two_lanes(w_sel_width);
                        w_addr_a_nxt  = w_sel_addr;
                        w_addr_b_nxt  = w_sel_addr + 32'd1;
                        w_wdata_a_nxt = w_sel_wdata[7:0];
                        w_wdata_b_nxt = w_sel_wdata[15:8];
                    end else begin
                        // Illegal width: acknowledge without touching memory
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_LO: begin
                if (w_is_word) begin
                    w_state_nxt   = ST_HI;
                    w_en_nxt      = 1'b1;
                    w_we_a_nxt    = r_we;
                    w_we_b_nxt    = r_we;
                    w_addr_a_nxt  = r_addr + 32'd2;
                    w_addr_b_nxt  = r_addr + 32'd3;
                    w_wdata_a_nxt = r_wdata[23:16];
                    w_wdata_b_nxt = r_wdata[31:24];
                end else begin
                    w_state_nxt = ST_FIN;
                end
            end
            ST_HI: begin
                w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
                w_rv0_nxt   = ~r_owner;
                w_rv1_nxt   = r_owner;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registered memory and requester outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en      <= 1'b0;
            mem_we_a    <= 1'b0;
            mem_we_b    <= 1'b0;
            mem_addr_a  <= 32'h0;
            mem_addr_b  <= 32'h0;
            mem_wdata_a <= 8'h0;
            mem_wdata_b <= 8'h0;
            m0_gnt      <= 1'b0;
            m1_gnt      <= 1'b0;
            m0_rvalid   <= 1'b0;
            m1_rvalid   <= 1'b0;
            m0_rdata    <= 32'h0;
            m1_rdata    <= 32'h0;
        end else begin
            mem_en      <= w_en_nxt;
            mem_we_a    <= w_we_a_nxt;
            mem_we_b    <= w_we_b_nxt;
            mem_addr_a  <= w_addr_a_nxt;
            mem_addr_b  <= w_addr_b_nxt;
            mem_wdata_a <= w_wdata_a_nxt;
            mem_wdata_b <= w_wdata_b_nxt;
            m0_gnt      <= w_gnt0_nxt;
            m1_gnt      <= w_gnt1_nxt;
            m0_rvalid   <= w_rv0_nxt;
            m1_rvalid   <= w_rv1_nxt;
            if (w_rv0_nxt) begin
                m0_rdata <= w_resp;
            end
            if (w_rv1_nxt) begin
                m1_rdata <= w_resp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Latched transaction fields and round-robin history
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_last <= 1'b1;
            r_owner   <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'h0;
            r_wdata   <= 32'h0;
            r_width   <= 3'b000;
            r_lo16    <= 16'h0;
        end else begin
            if (w_start) begin
                r_rr_last <= w_pick_m1;
                r_owner   <= w_pick_m1;
                r_we      <= w_sel_we;
                r_addr    <= w_sel_addr;
                r_wdata   <= w_sel_wdata;
                r_width   <= w_sel_width;
            end
            if (r_state == ST_HI) begin
                r_lo16 <= {mem_rdata_b, mem_rdata_a};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Scoreboard bench for mem_port_arbiter with a byte-lane memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [31:0] rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = 32'h0, m0_wdata = 32'h0;
    logic [2:0]  m0_width = 3'b000;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = 32'h0, m1_wdata = 32'h0;
    logic [2:0]  m1_width = 3'b000;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_en, mem_we_a, mem_we_b;
    logic [31:0] mem_addr_a, mem_addr_b;
    logic [7:0]  mem_wdata_a, mem_wdata_b;
    logic [7:0]  mem_rdata_a = 8'h00, mem_rdata_b = 8'h00;

    logic        fp_m0_req = 1'b0, fp_m1_req = 1'b0;
    logic        fp_m0_gnt, fp_m0_rvalid, fp_m1_gnt, fp_m1_rvalid;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_mem_en, fp_mem_we_a, fp_mem_we_b;
    logic [31:0] fp_mem_addr_a, fp_mem_addr_b;
    logic [7:0]  fp_mem_wdata_a, fp_mem_wdata_b;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          fp_n0  = 0;
    int          fp_n1  = 0;
    int          gcyc [2];
    bit          chk_beats = 1'b1;

    int          exp_gnt [$];
    exp_t        exp_q0  [$];
    exp_t        exp_q1  [$];
    logic [81:0] beat_q  [$];
    logic [7:0]  mem [4096];

    mem_port_arbiter #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_width(m0_width), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_width(m1_width), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
        .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
        .mem_wdata_a(mem_wdata_a), .mem_wdata_b(mem_wdata_b),
        .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b)
    );

    mem_port_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_req(fp_m0_req), .m0_we(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
        .m0_width(W_B), .m0_gnt(fp_m0_gnt), .m0_rvalid(fp_m0_rvalid), .m0_rdata(fp_m0_rdata),
        .m1_req(fp_m1_req), .m1_we(1'b0), .m1_addr(32'h10), .m1_wdata(32'h0),
        .m1_width(W_B), .m1_gnt(fp_m1_gnt), .m1_rvalid(fp_m1_rvalid), .m1_rdata(fp_m1_rdata),
        .mem_en(fp_mem_en), .mem_we_a(fp_mem_we_a), .mem_we_b(fp_mem_we_b),
        .mem_addr_a(fp_mem_addr_a), .mem_addr_b(fp_mem_addr_b),
        .mem_wdata_a(fp_mem_wdata_a), .mem_wdata_b(fp_mem_wdata_b),
        .mem_rdata_a(8'h00), .mem_rdata_b(8'h00)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Byte-lane memory: read data appears one cycle after an enabled access
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
        mem[12'h203] = 8'h80;
        mem[12'h210] = 8'h5A; mem[12'h211] = 8'hA5;
        mem[12'h220] = 8'h34; mem[12'h221] = 8'h92; mem[12'h222] = 8'h78; mem[12'h223] = 8'h56;
        mem[12'h400] = 8'h01; mem[12'h401] = 8'h02; mem[12'h402] = 8'h03; mem[12'h403] = 8'h04;
        forever begin
            @(posedge clk);
            if (mem_en) begin
                mem_rdata_a <= mem[mem_addr_a[11:0]];
                mem_rdata_b <= mem[mem_addr_b[11:0]];
                if (mem_we_a) mem[mem_addr_a[11:0]] = mem_wdata_a;
                if (mem_we_b) mem[mem_addr_b[11:0]] = mem_wdata_b;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_resp(input int m, input logic [31:0] rd);
        exp_t e;
        bit   empty;
        empty = (m == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        if (empty) begin
            checks++;
            errors++;
            $display("FAIL rvalid_unexpected m%0d got rdata %h expected no response", m, rd);
        end else begin
            e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rdata_m%0d", m), rd, e.rd);
            chk($sformatf("latency_m%0d", m), cyc - gcyc[m], e.lat);
        end
    endtask

    // Monitor: grants, responses and memory beats against the queues
    initial begin
        logic [81:0] b_act;
        logic [81:0] b_exp;
        int          who;
        int          e;
        forever begin
            @(negedge clk);
            if (m0_gnt || m1_gnt) begin
                chk("gnt_onehot", {31'h0, m0_gnt & m1_gnt}, 32'h0);
                who = m1_gnt ? 1 : 0;
                gcyc[who] = cyc;
                if (exp_gnt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL gnt_unexpected got m%0d expected none", who);
                end else begin
                    e = exp_gnt.pop_front();
                    chk("gnt_owner", who, e);
                end
            end
            if (m0_rvalid || m1_rvalid) begin
                chk("rvalid_onehot", {31'h0, m0_rvalid & m1_rvalid}, 32'h0);
                if (m0_rvalid) check_resp(0, m0_rdata);
                if (m1_rvalid) check_resp(1, m1_rdata);
            end
            if (mem_en) begin
                if (chk_beats) begin
                    b_act = {mem_we_a, mem_we_b, mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b};
                    checks++;
                    if (beat_q.size() == 0) begin
                        errors++;
                        $display("FAIL beat_unexpected got %h expected none", b_act);
                    end else begin
                        b_exp = beat_q.pop_front();
                        if (b_act !== b_exp) begin
                            errors++;
                            $display("FAIL beat got %h expected %h", b_act, b_exp);
                        end
                    end
                end
            end else begin
                chk("idle_we", {30'h0, mem_we_a, mem_we_b}, 32'h0);
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (fp_m0_gnt) fp_n0++;
        if (fp_m1_gnt) fp_n1++;
    end

    task automatic push_beat(input logic wa, input logic wb, input logic [31:0] aa,
                             input logic [31:0] ab, input logic [7:0] da, input logic [7:0] db);
        beat_q.push_back({wa, wb, aa, ab, da, db});
    endtask

    task automatic push_exp(input int m, input logic [31:0] rd, input int lat);
        exp_t e;
        e.rd  = rd;
        e.lat = lat;
        if (m == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Raise a request with stable fields and hold it until granted
    task automatic issue(input int m, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] width);
        bit got;
        got = 1'b0;
        if (m == 0) begin
            m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_width = width; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_width = width; m1_req = 1'b1;
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_gnt : m1_gnt;
        end
        if (m == 0) m0_req = 1'b0;
        else        m1_req = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL gnt_timeout m%0d got no grant expected grant", m);
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q0.size() + exp_q1.size() + exp_gnt.size() +
                (chk_beats ? beat_q.size() : 0)) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL drain_timeout got %0d pending expected 0",
                     exp_q0.size() + exp_q1.size() + exp_gnt.size() + beat_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        gcyc[0] = 0;
        gcyc[1] = 0;
        repeat (2) @(negedge clk);
        chk("rst_mem_ctl", {29'h0, mem_en, mem_we_a, mem_we_b}, 32'h0);
        chk("rst_addr_a", mem_addr_a, 32'h0);
        chk("rst_addr_b", mem_addr_b, 32'h0);
        chk("rst_wdata", {16'h0, mem_wdata_a, mem_wdata_b}, 32'h0);
        chk("rst_hs", {28'h0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed priority: m0 takes every grant under continuous contention
        fp_m0_req = 1'b1;
        fp_m1_req = 1'b1;
        repeat (9) @(negedge clk);
        fp_m0_req = 1'b0;
        fp_m1_req = 1'b0;
        chk("fp_m0_grants", fp_n0, 3);
        chk("fp_m1_grants", fp_n1, 0);
        repeat (4) @(negedge clk);

        // Word load
        exp_gnt.push_back(1);
        push_beat(1'b0, 1'b0, 32'h100, 32'h101, 8'h00, 8'h00);
        push_beat(1'b0, 1'b0, 32'h102, 32'h103, 8'h00, 8'h00);
        push_exp(1, 32'h44332211, 3);
        issue(1, 1'b0, 32'h100, 32'h0, W_W);
        wait_done();

        // Signed then unsigned byte
        exp_gnt.push_back(1);
        push_beat(1'b0, 1'b0, 32'h203, 32'h204, 8'h00, 8'h00);
        push_exp(1, 32'hFFFFFF80, 2);
        issue(1, 1'b0, 32'h203, 32'h0, W_B);
        wait_done();
        exp_gnt.push_back(1);
        push_beat(1'b0, 1'b0, 32'h203, 32'h204, 8'h00, 8'h00);
        push_exp(1, 32'h00000080, 2);
        issue(1, 1'b0, 32'h203, 32'h0, W_BU);
        wait_done();

        // Store half: one LO beat, both lanes
        exp_gnt.push_back(1);
        push_beat(1'b1, 1'b1, 32'h300, 32'h301, 8'hEF, 8'hBE);
        push_exp(1, 32'h0, 2);
        issue(1, 1'b1, 32'h300, 32'hDEADBEEF, W_H);
        wait_done();
        chk("sh_mem", {16'h0, mem[12'h301], mem[12'h300]}, 32'h0000BEEF);
        chk("sh_mem_hi", {24'h0, mem[12'h302]}, 32'h0);

        // Round-robin contention
        chk_beats = 1'b0;
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        exp_gnt.push_back(0);
        exp_gnt.push_back(1);
        push_exp(0, 32'h0000005A, 2);
        push_exp(0, 32'hFFFFFFA5, 2);
        push_exp(1, 32'hFFFF9234, 2);
        push_exp(1, 32'h00005678, 2);
        fork
            begin
                issue(0, 1'b0, 32'h210, 32'h0, W_BU);
                issue(0, 1'b0, 32'h211, 32'h0, W_B);
            end
            begin
                issue(1, 1'b0, 32'h220, 32'h0, W_H);
                issue(1, 1'b0, 32'h222, 32'h0, W_HU);
            end
        join
        wait_done();
        chk_beats = 1'b1;

        // Illegal width: no memory beat, zero response one cycle after grant
        exp_gnt.push_back(0);
        push_exp(0, 32'h0, 1);
        issue(0, 1'b0, 32'h500, 32'h12345678, 3'b011);
        wait_done();

        // Asynchronous reset during HI of a word store
        exp_gnt.push_back(1);
        push_beat(1'b1, 1'b1, 32'h400, 32'h401, 8'h0D, 8'hF0);
        issue(1, 1'b1, 32'h400, 32'hCAFEF00D, W_W);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_mem_ctl", {29'h0, mem_en, mem_we_a, mem_we_b}, 32'h0);
        chk("arst_addr", mem_addr_a | mem_addr_b, 32'h0);
        chk("arst_wdata", {16'h0, mem_wdata_a, mem_wdata_b}, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("arst_lo_kept", {mem[12'h403], mem[12'h402], mem[12'h401], mem[12'h400]}, 32'h0403F00D);
        repeat (6) @(negedge clk);

        // Service resumes from IDLE after reset
        exp_gnt.push_back(0);
        push_beat(1'b0, 1'b0, 32'h400, 32'h401, 8'h00, 8'h00);
        push_beat(1'b0, 1'b0, 32'h402, 32'h403, 8'h00, 8'h00);
        push_exp(0, 32'h0403F00D, 3);
        issue(0, 1'b0, 32'h400, 32'h0, W_W);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
